muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have port Clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port OpMul  input  1  1 = MUL (op_MUL), 0 = DIV (op_DIV); equals IR[12].
REQ-006 SHALL have port SR1  input  WIDTH  first operand (multiplicand/dividend), two's complement.
REQ-007 SHALL have port SR2  input  WIDTH  second operand (multiplier/divisor), two's complement.
REQ-008 SHALL have port Result  output  WIDTH  product low WIDTH bits or quotient.
REQ-009 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port Done  output  1  one-cycle pulse, Result valid.
REQ-011 SHALL have port DivZero  output  1  set with Done when DIV had SR2 = 0.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 IDLE: Start=1 SHALL latch |SR1|, |SR2|, result sign (XOR of operand MSBs), OpMul; clear counter; go CALC.
REQ-014 IDLE, DIV with SR2=0: SHALL skip CALC, go FIX with divide-by-zero flag set.
REQ-015 CALC: SHALL process one magnitude bit per cycle (MUL shift-add, DIV restoring shift-subtract); exactly WIDTH cycles, then FIX.
REQ-016 Arithmetic SHALL use unsigned WIDTH-bit magnitudes; |-2^(WIDTH-1)| = 2^(WIDTH-1) unsigned.
REQ-017 FIX: SHALL negate magnitude if sign=1, load Result; go DONE.
REQ-018 MUL result SHALL be low WIDTH bits of signed product (wraps silently).
REQ-019 DIV result SHALL truncate toward zero; -2^(WIDTH-1) / -1 SHALL yield 16'h8000 (wrap); remainder discarded.
REQ-020 Divide-by-zero SHALL yield Result = 0, DivZero = 1.
REQ-021 DONE: Done = 1 for exactly one cycle; next state IDLE unconditionally.
REQ-022 Latency: Done SHALL assert WIDTH+2 cycles after the Start-sampling edge (18 for WIDTH=16); divide-by-zero: 2 cycles.
REQ-023 Start while Busy SHALL be ignored (no queueing, no restart).
REQ-024 SR1/SR2/OpMul changes after the Start edge SHALL NOT affect the result.
REQ-025 Result and DivZero SHALL hold their values until the next FIX.
REQ-026 Back-to-back: Start in the IDLE cycle directly after DONE SHALL be accepted.

Reset
REQ-027 Reset_n=0 SHALL immediately force IDLE, Result=0, Busy=0, Done=0, DivZero=0, counter=0.
REQ-028 Reset mid-CALC/FIX SHALL abort with no Done pulse; first post-reset Start behaves normally.

Structure
REQ-029 State enum type and WIDTH constant SHALL live in the shared SLC3_2 package beside op_MUL/op_DIV.
REQ-030 SHALL be a single module; no sub-module; sign correction inline.
REQ-031 ISA decode SHALL drive Start/OpMul; the unit SHALL NOT decode IR itself.

Verification
REQ-032 MUL SR1=7, SR2=-3 -> Result=16'hFFEB, Done at cycle 18, DivZero=0.
REQ-033 MUL SR1=300, SR2=300 -> Result=16'h5F90 (wrap).
REQ-034 DIV SR1=-7, SR2=2 -> Result=16'hFFFD; DIV SR1=16'h8000, SR2=-1 -> 16'h8000.
REQ-035 DIV SR1=5, SR2=0 -> Done at cycle 2, Result=0, DivZero=1.
REQ-036 Start at cycle 5 of CALC (operands changed) -> ignored, original result unchanged at cycle 18.
REQ-037 Reset_n low at cycle 9 of a MUL -> outputs zero same cycle, no Done; next MUL 4*5 -> 16'h0014.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared SLC3_2 definitions: MUL/DIV opcode bit values, the default datapath
// width and the state type of the sequential multiply/divide unit.
package SLC3_2;

    localparam int MULDIV_WIDTH = 16;

    // Values of IR[12] as delivered on OpMul by the instruction decoder.
    localparam logic op_MUL = 1'b1;
    localparam logic op_DIV = 1'b0;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Sequential signed multiply / divide unit: one magnitude bit per cycle on
// unsigned magnitudes, with the result sign applied once in a FIX step.
module muldiv_seq
    import SLC3_2::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             OpMul,
    input  logic [WIDTH-1:0] SR1,
    input  logic [WIDTH-1:0] SR2,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + ONE) : v;
    endfunction

    md_state_e        r_state;
    md_state_e        w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_sign;
    logic             r_op;
    logic             r_dz;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_div_zero;

    logic             w_sr2_zero;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_mag_res;
    logic [WIDTH-1:0] w_signed_res;
    logic             w_busy;
    logic             w_done;

    assign w_sr2_zero = (SR2 == ZERO);

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a divide by zero bypasses CALC entirely.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MD_IDLE: begin
                if (Start) begin
                    w_next_state = ((OpMul == op_DIV) && w_sr2_zero) ? MD_FIX : MD_CALC;
                end else begin
                    w_next_state = MD_IDLE;
                end
            end
            MD_CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = MD_FIX;
                end else begin
                    w_next_state = MD_CALC;
                end
            end
            MD_FIX:  w_next_state = MD_DONE;
            MD_DONE: w_next_state = MD_IDLE;
            default: w_next_state = MD_IDLE;
        endcase
    end

    // Restoring-division step: remainder shifted left with the next dividend bit.
    always_comb begin
        w_div_shift  = {r_acc, r_a[WIDTH-1]};
        w_div_diff   = w_div_shift - {1'b0, r_b};
        w_div_ge     = ~w_div_diff[WIDTH];
        w_div_rem    = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
        w_mag_res    = (r_op == op_MUL) ? r_acc : r_a;
        w_signed_res = r_sign ? (~w_mag_res + ONE) : w_mag_res;
    end

    // Operand capture and iterative datapath; r_a doubles as quotient shift register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_a    <= ZERO;
            r_b    <= ZERO;
            r_acc  <= ZERO;
            r_sign <= 1'b0;
            r_op   <= 1'b0;
            r_dz   <= 1'b0;
            r_cnt  <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (Start) begin
                        r_a    <= mag(SR1);
                        r_b    <= mag(SR2);
                        r_acc  <= ZERO;
                        r_sign <= SR1[WIDTH-1] ^ SR2[WIDTH-1];
                        r_op   <= OpMul;
                        r_dz   <= (OpMul == op_DIV) && w_sr2_zero;
                        r_cnt  <= {CNT_W{1'b0}};
                    end
                end
                MD_CALC: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_op == op_MUL) begin
                        if (r_b[0]) begin
                            r_acc <= r_acc + r_a;
                        end
                        r_a <= r_a << 1;
                        r_b <= r_b >> 1;
                    end else begin
                        r_acc <= w_div_rem;
                        r_a   <= {r_a[WIDTH-2:0], w_div_ge};
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Result/DivZero are loaded only on leaving FIX and hold otherwise.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_result   <= ZERO;
            r_div_zero <= 1'b0;
        end else if (r_state == MD_FIX) begin
            r_result   <= r_dz ? ZERO : w_signed_res;
            r_div_zero <= r_dz;
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        w_busy = 1'b1;
        w_done = 1'b0;
        case (r_state)
            MD_IDLE: w_busy = 1'b0;
            MD_DONE: w_done = 1'b1;
            default: begin
                w_busy = 1'b1;
                w_done = 1'b0;
            end
        endcase
    end

    assign Result  = r_result;
    assign DivZero = r_div_zero;
    assign Busy    = w_busy;
    assign Done    = w_done;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized bench for muldiv_seq against an arithmetic reference model,
// with directed cases for known results, latency, ignored Start and reset abort.
module tb_muldiv_seq;

    localparam int W = 16;

    logic          Clk     = 1'b0;
    logic          Reset_n = 1'b1;
    logic          Start   = 1'b0;
    logic          OpMul   = 1'b0;
    logic [W-1:0]  SR1     = 16'h0000;
    logic [W-1:0]  SR2     = 16'h0000;
    logic [W-1:0]  Result;
    logic          Busy;
    logic          Done;
    logic          DivZero;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .OpMul   (OpMul),
        .SR1     (SR1),
        .SR2     (SR2),
        .Result  (Result),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero)
    );

    // Signed reference arithmetic: wrapped product, truncating quotient, 0 on /0.
    function automatic logic [15:0] ref_result(input logic op, input logic [15:0] a,
                                               input logic [15:0] b);
        longint     sa;
        longint     sb;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op) t = 64'(sa * sb);
        else if (b == 16'h0000) t = 64'd0;
        else t = 64'(sa / sb);
        return t[15:0];
    endfunction

    function automatic logic [15:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: m_cyc counts cycles into an operation (0 = idle).
    int          m_cyc = 0;
    int          m_len = 0;
    logic [15:0] m_res = 16'h0000;
    logic        m_dz  = 1'b0;
    logic [15:0] p_res = 16'h0000;
    logic        p_dz  = 1'b0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_cyc <= 0;
            m_len <= 0;
            m_res <= 16'h0000;
            m_dz  <= 1'b0;
        end else if (m_cyc == 0) begin
            if (Start === 1'b1) begin
                p_res <= ref_result(OpMul, SR1, SR2);
                p_dz  <= !OpMul && (SR2 == 16'h0000);
                m_len <= (!OpMul && (SR2 == 16'h0000)) ? 2 : W + 2;
                m_cyc <= 1;
            end
        end else if (m_cyc == m_len) begin
            m_cyc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc + 1 == m_len) begin
                m_res <= p_res;
                m_dz  <= p_dz;
            end
        end
    end

    always @(negedge Clk) begin
        check("busy",    16'(Busy),    16'(m_cyc != 0));
        check("done",    16'(Done),    16'((m_cyc != 0) && (m_cyc == m_len)));
        check("result",  Result,       m_res);
        check("divzero", 16'(DivZero), 16'(m_dz));
    end

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        @(negedge Clk);
        while (Busy !== 1'b0 && guard < 40) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 40) check({tag, " idle timeout"}, 16'(Busy), 16'h0000);
    endtask

    task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic exp_dz, input int exp_cyc,
                          input int poke_cyc, input string tag);
        int done_cyc;
        wait_idle(tag);
        Start = 1'b1;
        OpMul = op;
        SR1   = a;
        SR2   = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        OpMul = 1'($urandom_range(0, 1));
        SR1   = 16'($urandom);
        SR2   = 16'($urandom);
        done_cyc = 0;
        for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
            if (k == poke_cyc) begin
                Start = 1'b1;
                SR1   = 16'($urandom);
                SR2   = 16'($urandom);
            end else begin
                Start = 1'b0;
            end
            @(posedge Clk);
            #1;
            if (Done === 1'b1) done_cyc = k + 1;
        end
        Start = 1'b0;
        check({tag, " done cycle"}, 16'(done_cyc), 16'(exp_cyc));
        check({tag, " result"}, Result, exp_res);
        check({tag, " divzero"}, 16'(DivZero), 16'(exp_dz));
    endtask

    initial begin
        // Pin the reference model to hand-computed values.
        check("model mul 7*-3",   ref_result(1'b1, 16'd7, 16'hFFFD),    16'hFFEB);
        check("model mul 300^2",  ref_result(1'b1, 16'd300, 16'd300),  16'h5F90);
        check("model div -7/2",   ref_result(1'b0, 16'hFFF9, 16'd2),    16'hFFFD);
        check("model div min/-1", ref_result(1'b0, 16'h8000, 16'hFFFF), 16'h8000);
        check("model div 5/0",    ref_result(1'b0, 16'd5, 16'h0000),    16'h0000);

        #1 Reset_n = 1'b0;
        #10;
        check("reset result",  Result,       16'h0000);
        check("reset busy",    16'(Busy),    16'h0000);
        check("reset done",    16'(Done),    16'h0000);
        check("reset divzero", 16'(DivZero), 16'h0000);
        @(negedge Clk);
        Reset_n = 1'b1;

        run_op(1'b1, 16'd7,    16'hFFFD, 16'hFFEB, 1'b0, 18, 0, "mul 7*-3");
        run_op(1'b1, 16'd300,  16'd300,  16'h5F90, 1'b0, 18, 0, "mul 300*300");
        run_op(1'b0, 16'hFFF9, 16'd2,    16'hFFFD, 1'b0, 18, 0, "div -7/2");
        run_op(1'b0, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 18, 0, "div min/-1");
        run_op(1'b0, 16'd5,    16'h0000, 16'h0000, 1'b1, 2,  0, "div 5/0");
        run_op(1'b1, 16'd7,    16'hFFFD, 16'hFFEB, 1'b0, 18, 5, "mul start while busy");
        run_op(1'b1, 16'd300,  16'd300,  16'h5F90, 1'b0, 18, 0, "mul pre-reset");

        // Abort a multiply in its ninth cycle with an asynchronous reset.
        wait_idle("abort");
        Start = 1'b1;
        OpMul = 1'b1;
        SR1   = 16'd123;
        SR2   = 16'd45;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (8) @(posedge Clk);
        #2;
        check("abort held result", Result, 16'h5F90);
        Reset_n = 1'b0;
        #1;
        check("abort result",  Result,       16'h0000);
        check("abort busy",    16'(Busy),    16'h0000);
        check("abort done",    16'(Done),    16'h0000);
        check("abort divzero", 16'(DivZero), 16'h0000);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        run_op(1'b1, 16'd4, 16'd5, 16'h0014, 1'b0, 18, 0, "mul 4*5 after reset");

        for (int i = 0; i < 6000; i++) begin
            @(negedge Clk);
            Start = ($urandom_range(0, 3) == 0);
            OpMul = 1'($urandom_range(0, 1));
            SR1   = rnd_opnd();
            SR2   = rnd_opnd();
        end
        @(negedge Clk);
        Start = 1'b0;
        repeat (25) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
